// File: rtl/dmem_pkg.sv
// Shared types, default geometry and line-index helper for the data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam int LINE_BITS_DEF = 256;
  localparam int DEPTH_DEF     = 512;
  localparam int LATENCY_DEF   = 10;
  localparam int OFFSET_BITS   = $clog2(LINE_BITS_DEF / 8);
  localparam int INDEX_BITS    = $clog2(DEPTH_DEF);
  localparam int CNT_BITS      = $clog2(LATENCY_DEF + 1);

  function automatic logic [63:0] line_index(
    input logic [63:0] addr,
    input int unsigned off_bits
  );
    return addr >> off_bits;
  endfunction

endpackage

// File: rtl/dmem_latency_timer.sv
// Counts 1..LATENCY after start_i; done_o marks the final count.
module dmem_latency_timer #(
  parameter int LATENCY = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic done_o
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  assign done_o = busy_q && (cnt_q == CW'(LATENCY));

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(1);
    end else if (done_o) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/data_memory_line_param.sv
// Line-granular main memory with fixed response latency.
// DMEM_WSTRB_EN enables per-byte write strobes.
module data_memory_line_param
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   write_i,
  input  logic [ADDR_BITS-1:0]   addr_i,
  input  logic [LINE_BITS-1:0]   data_i,
  input  logic [LINE_BITS/8-1:0] wstrb_i,
  output logic                   ready_o,
  output logic                   ack_o,
  output logic                   err_o,
  output logic [LINE_BITS-1:0]   data_o
);

  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = LINE_BITS / 8;

  state_e               state_q, state_d;
  logic [LINE_BITS-1:0] mem_q [DEPTH];
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic [LINE_BITS-1:0] wdata_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 err_q, err_d;
  logic                 wr_q, rng_q;
  logic                 accept, done, commit;

  assign ready_o = (state_q == IDLE) && !rst_i;
  assign accept  = ready_o && enable_i;
  assign ack_o   = (state_q == RESP);
  assign err_o   = err_q;
  assign data_o  = rdata_q;

  dmem_latency_timer #(
    .LATENCY(LATENCY)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(accept),
    .done_o (done)
  );

`ifdef DMEM_WSTRB_EN
  logic [NB-1:0] strb_q;
  always_ff @(posedge clk_i) begin
    if (accept) strb_q <= wstrb_i;
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb_i;
`endif

  // Range is decided on the full address so huge addresses never alias.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q    <= write_i;
      wdata_q <= data_i;
      idx_q   <= IDX_W'(line_index(64'(addr_i), OFF_W));
      rng_q   <= line_index(64'(addr_i), OFF_W) < 64'(DEPTH);
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: if (enable_i) state_d = BUSY;
      BUSY: begin
        if (done) begin
          state_d = RESP;
          commit  = 1'b1;
          if (!rng_q) begin
            err_d = 1'b1;
            if (!wr_q) rdata_d = '0;
          end else if (!wr_q) begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && wr_q && rng_q) begin
`ifdef DMEM_WSTRB_EN
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
`else
      mem_q[idx_q] <= wdata_q;
`endif
    end
  end

endmodule

// File: doc/data_memory_line_param.md
Name: data_memory_line_param

Overview:
- Parametrised line-granular main-memory model behind the cache controller; successor of the fixed 256-bit/512-entry/10-cycle data memory.
- Latches the full request on acceptance and answers after a programmable fixed latency.
- Adds a ready/accept handshake, out-of-range error reporting and optional byte-strobed writes.
- Serves one outstanding request at a time.

Parameters:
- ADDR_BITS, 32, byte-address width.
- LINE_BITS, 256, line width; power of two, >= 32.
- DEPTH, 512, number of lines; power of two.
- LATENCY, 10, cycles from accept to ack; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  request valid.
- write_i  in  1  1 = write, 0 = read; sampled on accept.
- addr_i  in  ADDR_BITS  byte address; sampled on accept.
- data_i  in  LINE_BITS  write line; sampled on accept.
- wstrb_i  in  LINE_BITS/8  byte write enables; sampled on accept.
- ready_o  out  1  can accept a request this cycle.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with ack_o; address out of range.
- data_o  out  LINE_BITS  read line.

Behaviour:
- Synchronous active-high reset. All of the following are set on any clock edge with rst_i = 1:
  - state = IDLE, counter = 0.
  - ack_o = 0, err_o = 0, data_o = 0.
  - ready_o = 0 while rst_i = 1.
- Memory array contents are not reset.
- Accept: a rising edge with ready_o = 1 and enable_i = 1. On accept, addr_i, write_i, data_i and wstrb_i are latched. Inputs are don't-care afterwards until the next accept.
- Line index = addr_i >> log2(LINE_BITS/8). Offset bits are ignored. Out of range when index >= DEPTH; compare on full width, no truncation or wrap.
- State machine:
  - IDLE: ready_o = 1. On accept, go to BUSY and set count = 1.
  - BUSY: ready_o = 0. If count == LATENCY, go to RESP; otherwise count++.
  - RESP: ack_o = 1 for exactly this one cycle. Next state is IDLE.
- Latency: with accept at edge N, ack_o is high in the cycle after edge N+LATENCY. Minimum request-to-request spacing is LATENCY+2 edges.
- LATENCY = 1: BUSY lasts one cycle.
- No request is accepted during BUSY or RESP; enable_i is ignored there.
- The read or write takes effect at the edge that enters RESP:
  - Read, in range: data_o = mem[index].
  - Write, in range: mem[index] bytes with wstrb = 1 are updated. data_o is unchanged.
  - Out of range: err_o = 1 in RESP. No memory update. A read sets data_o = 0.
- data_o holds its value until the next completed read.
- err_o is 0 whenever ack_o = 0.
- Reset mid-operation (BUSY or RESP): request abandoned, no memory write, no ack_o.
- A write followed by a read of the same line returns the new data, because the write commits before ready_o returns.

Optional Feature:
- Macro DMEM_WSTRB_EN.
- Defined: writes honour wstrb_i per byte. All-zero strobes complete with ack_o but leave memory unchanged.
- Undefined: wstrb_i is ignored and every write replaces the whole line. The port stays present for a stable interface.

Decomposition:
- Package dmem_pkg holds:
  - state encoding typedef (IDLE/BUSY/RESP);
  - localparams OFFSET_BITS = $clog2(LINE_BITS/8), INDEX_BITS = $clog2(DEPTH), CNT_BITS = $clog2(LATENCY+1);
  - helper function computing the line index.
- One natural sub-module, dmem_latency_timer:
  - load/start, count up to LATENCY, done flag;
  - reused by the future instruction-memory model.
- Array and FSM stay in the top module.

Test Plan:
- Reset: hold rst_i 3 cycles, then release → ready_o 0 during reset and 1 after; ack_o, err_o, data_o all 0.
- Write then read, LATENCY=10:
  - write addr 0x40, data 0xA5 repeated, accepted at edge 0 → ack_o only in the cycle after edge 10;
  - read 0x40 → data_o = 0xA5 pattern.
- Offset ignore: read 0x5F after writing line 0x40 → same data (index 2).
- Out of range, DEPTH=512: read addr 512*32 → err_o = 1 with ack_o, data_o = 0; a write there leaves all lines unchanged.
- Busy protection: hold enable_i high continuously → accepts spaced exactly LATENCY+2 edges; each returns one ack pulse; no double accept.
- With DMEM_WSTRB_EN, LATENCY=1:
  - write strobe 0x0000000F with 0xFF.. over a zero line → read gives low 4 bytes 0xFF, rest 0;
  - reset asserted during BUSY of a write → no ack, and the line reads unchanged.
